// File: rtl/conv_kernel_param.sv
// Command/ack encodings shared by both ends of the conv-layer controller protocol,
// plus the input-interface state type.
package conv_kernel_param;

    localparam logic [1:0] CMD_IDLE    = 2'd0;
    localparam logic [1:0] CMD_PRELOAD = 2'd1;
    localparam logic [1:0] CMD_SHIFT   = 2'd2;
    localparam logic [1:0] CMD_LOAD    = 2'd3;

    localparam logic [1:0] ACK_IDLE        = 2'd0;
    localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
    localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
    localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRELOAD = 2'd1,
        S_LOAD    = 2'd2,
        S_SHIFT   = 2'd3
    } if_state_t;

    function automatic logic [1:0] ack_for(input if_state_t s);
        case (s)
            S_PRELOAD: return ACK_PRELOAD_FIN;
            S_LOAD:    return ACK_LOAD_FIN;
            S_SHIFT:   return ACK_SHIFT_FIN;
            default:   return ACK_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/conv_row_buffer.sv
// K x IMG_W pixel store: one write port (slot, column) and a column read port
// returning every slot unrotated; slot s sits in lane s of rd_data.
module conv_row_buffer #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 6,
    parameter int K      = 3,
    parameter int SLOT_W = 2,
    parameter int COL_W  = 3
) (
    input  logic                clk,
    input  logic                we,
    input  logic [SLOT_W-1:0]   wr_slot,
    input  logic [COL_W-1:0]    wr_col,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [COL_W-1:0]    rd_col,
    output logic [K*DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] buf_q [K][IMG_W];
    logic [DATA_W-1:0] buf_d [K][IMG_W];

    always_comb begin
        buf_d = buf_q;
        if (we) begin
            buf_d[wr_slot][wr_col] = wr_data;
        end
    end

    // Pixel storage carries no reset; contents are qualified by the parent's buf_valid.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_comb begin
        rd_data = '0;
        for (int s = 0; s < K; s++) begin
            rd_data[s*DATA_W +: DATA_W] = buf_q[s][rd_col];
        end
    end

endmodule

// File: rtl/conv_input_interface.sv
// Responder side of the conv-layer command/ack protocol: fetches feature-map rows
// into a K-row buffer and streams buffer columns (oldest row in lane 0) to the kernel array.
module conv_input_interface
    import conv_kernel_param::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 6,
    parameter int IMG_H  = 6,
    parameter int K      = 3,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          cmd,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic [1:0]          ack,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rd_data,
    output logic [K*DATA_W-1:0] col_data,
    output logic                col_valid,
    output logic                col_last,
    output logic                cmd_err
);

    localparam int CNT_W  = $clog2(K * IMG_W + 1);
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int SLOT_W = (K > 1) ? $clog2(K) : 1;
    localparam int ROW_W  = $clog2(IMG_H + 1);
    localparam logic [CNT_W-1:0] PRE_N  = CNT_W'(K * IMG_W);
    localparam logic [CNT_W-1:0] LOAD_N = CNT_W'(IMG_W);

    function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
        return (s == SLOT_W'(K - 1)) ? '0 : s + 1'b1;
    endfunction

    if_state_t           state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ROW_W-1:0]    row_ptr_q, row_ptr_d;
    logic [SLOT_W-1:0]   top_q, top_d;
    logic                buf_valid_q, buf_valid_d;
    logic                skip_q, skip_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [SLOT_W-1:0]   wr_slot_q, wr_slot_d;
    logic [COL_W-1:0]    wr_col_q, wr_col_d;
    logic [CNT_W-1:0]    col_q, col_d;
    logic [1:0]          ack_q, ack_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [K*DATA_W-1:0] col_data_q, col_data_d;
    logic                col_valid_q, col_valid_d;
    logic                col_last_q, col_last_d;
    logic                cmd_err_q, cmd_err_d;

    logic                buf_we;
    logic [COL_W-1:0]    rd_col;
    logic [K*DATA_W-1:0] buf_rd_data;
    logic [K*DATA_W-1:0] col_rot;
    logic [CNT_W-1:0]    n_tgt;

    conv_row_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .K      (K),
        .SLOT_W (SLOT_W),
        .COL_W  (COL_W)
    ) u_row_buffer (
        .clk     (clk),
        .we      (buf_we),
        .wr_slot (wr_slot_q),
        .wr_col  (wr_col_q),
        .wr_data (mem_rd_data),
        .rd_col  (rd_col),
        .rd_data (buf_rd_data)
    );

    assign rd_col = (state_q == S_SHIFT && col_q < LOAD_N) ? COL_W'(col_q) : '0;
    assign n_tgt  = (state_q == S_PRELOAD) ? PRE_N : LOAD_N;

    // Lane j shows the slot j rows after the oldest one.
    always_comb begin
        col_rot = '0;
        for (int j = 0; j < K; j++) begin
            col_rot[j*DATA_W +: DATA_W] = buf_rd_data[((int'(top_q) + j) % K)*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        row_ptr_d   = row_ptr_q;
        top_d       = top_q;
        buf_valid_d = buf_valid_q;
        skip_d      = skip_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        wr_slot_d   = wr_slot_q;
        wr_col_d    = wr_col_q;
        col_d       = col_q;
        ack_d       = ACK_IDLE;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        col_data_d  = col_data_q;
        col_valid_d = 1'b0;
        col_last_d  = 1'b0;
        cmd_err_d   = (state_q != S_IDLE) && (cmd != CMD_IDLE);

        // Read data arrives the cycle after each strobe and is retired into the buffer.
        buf_we = mem_rd_en_q;
        if (mem_rd_en_q) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_col_q == COL_W'(IMG_W - 1)) begin
                wr_col_d  = '0;
                wr_slot_d = slot_inc(wr_slot_q);
            end else begin
                wr_col_d = wr_col_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                case (cmd)
                    CMD_PRELOAD: begin
                        base_d      = base_addr;
                        row_ptr_d   = '0;
                        top_d       = '0;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = base_addr;
                        rd_cnt_d    = CNT_W'(1);
                        wr_cnt_d    = '0;
                        wr_slot_d   = '0;
                        wr_col_d    = '0;
                        state_d     = S_PRELOAD;
                    end
                    CMD_LOAD: begin
                        if ((int'(row_ptr_q) + K) < IMG_H) begin
                            mem_rd_en_d = 1'b1;
                            mem_addr_d  = base_q + ADDR_W'((int'(row_ptr_q) + K) * IMG_W);
                            rd_cnt_d    = CNT_W'(1);
                            wr_cnt_d    = '0;
                            wr_slot_d   = top_q;
                            wr_col_d    = '0;
                            skip_d      = 1'b0;
                        end else begin
                            cmd_err_d = 1'b1;
                            skip_d    = 1'b1;
                        end
                        state_d = S_LOAD;
                    end
                    CMD_SHIFT: begin
                        if (buf_valid_q) begin
                            col_valid_d = 1'b1;
                            col_last_d  = (IMG_W == 1);
                            col_data_d  = col_rot;
                            col_d       = CNT_W'(1);
                            state_d     = S_SHIFT;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_PRELOAD, S_LOAD: begin
                if (skip_q) begin
                    skip_d  = 1'b0;
                    ack_d   = ACK_LOAD_FIN;
                    state_d = S_IDLE;
                end else begin
                    if (rd_cnt_q < n_tgt) begin
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = mem_addr_q + 1'b1;
                        rd_cnt_d    = rd_cnt_q + 1'b1;
                    end
                    if (mem_rd_en_q && wr_cnt_q == n_tgt - 1'b1) begin
                        ack_d   = ack_for(state_q);
                        state_d = S_IDLE;
                        if (state_q == S_PRELOAD) begin
                            buf_valid_d = 1'b1;
                        end else begin
                            top_d     = slot_inc(top_q);
                            row_ptr_d = row_ptr_q + 1'b1;
                        end
                    end
                end
            end
            S_SHIFT: begin
                if (col_q < LOAD_N) begin
                    col_valid_d = 1'b1;
                    col_last_d  = (col_q == LOAD_N - 1'b1);
                    col_data_d  = col_rot;
                    col_d       = col_q + 1'b1;
                end else begin
                    ack_d   = ACK_SHIFT_FIN;
                    col_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            row_ptr_q   <= '0;
            top_q       <= '0;
            buf_valid_q <= 1'b0;
            skip_q      <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            wr_slot_q   <= '0;
            wr_col_q    <= '0;
            col_q       <= '0;
            ack_q       <= ACK_IDLE;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            col_data_q  <= '0;
            col_valid_q <= 1'b0;
            col_last_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            row_ptr_q   <= row_ptr_d;
            top_q       <= top_d;
            buf_valid_q <= buf_valid_d;
            skip_q      <= skip_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_slot_q   <= wr_slot_d;
            wr_col_q    <= wr_col_d;
            col_q       <= col_d;
            ack_q       <= ack_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            col_data_q  <= col_data_d;
            col_valid_q <= col_valid_d;
            col_last_q  <= col_last_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign ack       = ack_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign col_data  = col_data_q;
    assign col_valid = col_valid_q;
    assign col_last  = col_last_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_conv_input_interface.sv
// Scoreboard bench for conv_input_interface: the reference keeps the buffered rows as a
// sliding window of image rows and predicts every read, column, ack and error with its cycle.
module tb_conv_input_interface;
    import conv_kernel_param::*;

    localparam int DATA_W = 16;
    localparam int IMG_W  = 6;
    localparam int IMG_H  = 6;
    localparam int K      = 3;
    localparam int ADDR_W = 8;
    localparam int ROW_BITS = IMG_W * DATA_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [1:0]          cmd = CMD_IDLE;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [1:0]          ack;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_rd_data;
    logic [K*DATA_W-1:0] col_data;
    logic                col_valid;
    logic                col_last;
    logic                cmd_err;

    logic [DATA_W-1:0]   mem [256];
    int                  cyc = 0;
    int                  n_cmp = 0;
    int                  n_fail = 0;

    logic [127:0]        exp_rd_q[$];
    logic [127:0]        exp_col_q[$];
    logic [127:0]        exp_ack_q[$];
    logic [127:0]        exp_err_q[$];

    logic [ROW_BITS-1:0] win[$];
    logic [ADDR_W-1:0]   m_base = '0;
    int                  m_row = 0;
    bit                  m_valid = 1'b0;

    conv_input_interface #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .base_addr   (base_addr),
        .ack         (ack),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .col_data    (col_data),
        .col_valid   (col_valid),
        .col_last    (col_last),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory answers in the cycle following the edge that registered the strobe.
    assign mem_rd_data = mem_rd_en ? mem[mem_addr] : 16'hDEAD;

    function automatic logic [127:0] pk(input int t, input logic [63:0] v);
        return {32'b0, 32'(t), v};
    endfunction

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void unexpected(input string name, input logic [127:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %0h, expected nothing (t=%0t)", name, act, $time);
    endfunction

    function automatic logic [ROW_BITS-1:0] fetch_row(input logic [ADDR_W-1:0] start);
        logic [ROW_BITS-1:0] row;
        row = '0;
        for (int c = 0; c < IMG_W; c++) begin
            row[c*DATA_W +: DATA_W] = mem[8'(start + 8'(c))];
        end
        return row;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                if (exp_rd_q.size() == 0) unexpected("mem_read", pk(cyc, 64'(mem_addr)));
                else check("mem_read", pk(cyc, 64'(mem_addr)), exp_rd_q.pop_front());
            end
            if (col_valid) begin
                if (exp_col_q.size() == 0) unexpected("column", pk(cyc, {15'b0, col_last, col_data}));
                else check("column", pk(cyc, {15'b0, col_last, col_data}), exp_col_q.pop_front());
            end else if (col_last) begin
                unexpected("col_last_without_valid", pk(cyc, 64'(col_last)));
            end
            if (ack != ACK_IDLE) begin
                if (exp_ack_q.size() == 0) unexpected("ack", pk(cyc, 64'(ack)));
                else check("ack", pk(cyc, 64'(ack)), exp_ack_q.pop_front());
            end
            if (cmd_err) begin
                if (exp_err_q.size() == 0) unexpected("cmd_err", pk(cyc, 64'(0)));
                else check("cmd_err", pk(cyc, 64'(0)), exp_err_q.pop_front());
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_reads(input logic [ADDR_W-1:0] start, input int n, input int t0);
        for (int i = 0; i < n; i++) begin
            exp_rd_q.push_back(pk(t0 + i, 64'(8'(start + 8'(i)))));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},       128'(ack),       128'(0));
        check({tag, "_mem_rd_en"}, 128'(mem_rd_en), 128'(0));
        check({tag, "_mem_addr"},  128'(mem_addr),  128'(0));
        check({tag, "_col_data"},  128'(col_data),  128'(0));
        check({tag, "_col_valid"}, 128'(col_valid), 128'(0));
        check({tag, "_col_last"},  128'(col_last),  128'(0));
        check({tag, "_cmd_err"},   128'(cmd_err),   128'(0));
    endtask

    // k_intr >= 0 drives a stray command right after edge k_intr of the fetch.
    task automatic op_preload(input logic [ADDR_W-1:0] b, input int k_intr, input logic [1:0] c_intr);
        int e0;
        e0 = cyc + 1;
        push_reads(b, K * IMG_W, e0);
        exp_ack_q.push_back(pk(e0 + K * IMG_W, 64'(ACK_PRELOAD_FIN)));
        win.delete();
        for (int r = 0; r < K; r++) win.push_back(fetch_row(8'(b + 8'(r * IMG_W))));
        m_base = b;
        m_row = 0;
        m_valid = 1'b1;
        cmd = CMD_PRELOAD;
        base_addr = b;
        @(posedge clk);
        #1;
        cmd = CMD_IDLE;
        base_addr = 8'($urandom);
        if (k_intr >= 0) begin
            wait_until(e0 + k_intr);
            cmd = c_intr;
            base_addr = 8'($urandom);
            exp_err_q.push_back(pk(e0 + k_intr + 1, 64'(0)));
            @(posedge clk);
            #1;
            cmd = CMD_IDLE;
        end
        wait_until(e0 + K * IMG_W);
    endtask

    task automatic op_shift();
        int e0;
        int n;
        logic [K*DATA_W-1:0] d;
        e0 = cyc + 1;
        if (m_valid) begin
            for (int c = 0; c < IMG_W; c++) begin
                for (int j = 0; j < K; j++) d[j*DATA_W +: DATA_W] = win[j][c*DATA_W +: DATA_W];
                exp_col_q.push_back(pk(e0 + c, {15'b0, (c == IMG_W - 1), d}));
            end
            exp_ack_q.push_back(pk(e0 + IMG_W, 64'(ACK_SHIFT_FIN)));
            n = IMG_W;
        end else begin
            exp_err_q.push_back(pk(e0, 64'(0)));
            n = 0;
        end
        cmd = CMD_SHIFT;
        @(posedge clk);
        #1;
        cmd = CMD_IDLE;
        wait_until(e0 + n);
    endtask

    task automatic op_load();
        int e0;
        int n;
        logic [ADDR_W-1:0] start;
        e0 = cyc + 1;
        if (m_row + K < IMG_H) begin
            start = m_base + 8'((m_row + K) * IMG_W);
            push_reads(start, IMG_W, e0);
            exp_ack_q.push_back(pk(e0 + IMG_W, 64'(ACK_LOAD_FIN)));
            void'(win.pop_front());
            win.push_back(fetch_row(start));
            m_row++;
            n = IMG_W;
        end else begin
            exp_err_q.push_back(pk(e0, 64'(0)));
            exp_ack_q.push_back(pk(e0 + 1, 64'(ACK_LOAD_FIN)));
            n = 1;
        end
        cmd = CMD_LOAD;
        @(posedge clk);
        #1;
        cmd = CMD_IDLE;
        wait_until(e0 + n);
    endtask

    task automatic op_reset_mid(input int k);
        int e0;
        e0 = cyc + 1;
        base_addr = 8'($urandom);
        push_reads(base_addr, K * IMG_W, e0);
        cmd = CMD_PRELOAD;
        @(posedge clk);
        #1;
        cmd = CMD_IDLE;
        wait_until(e0 + k);
        #2;
        rst_n = 1'b0;
        exp_rd_q.delete();
        exp_col_q.delete();
        exp_ack_q.delete();
        exp_err_q.delete();
        win.delete();
        m_valid = 1'b0;
        m_row = 0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        op_preload(8'd0, -1, CMD_IDLE);
        op_shift();
        op_load();
        op_shift();
        op_load();
        op_load();
        op_load();
        op_shift();
        op_preload(8'd0, 5, CMD_SHIFT);
        op_shift();
        op_reset_mid(7);
        op_shift();
        op_preload(8'd0, -1, CMD_IDLE);
        op_shift();

        for (int it = 0; it < 80; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
                op_preload(8'($urandom), -1, CMD_IDLE);
            end else if (r <= 2) begin
                op_preload(8'($urandom), -1, CMD_IDLE);
            end else if (r <= 5) begin
                op_shift();
            end else if (r <= 8) begin
                op_load();
            end else begin
                op_preload(8'($urandom), int'($urandom_range(0, 16)), 2'($urandom_range(1, 3)));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        op_reset_mid(int'($urandom_range(1, 16)));
        op_shift();
        op_preload(8'($urandom), -1, CMD_IDLE);
        op_shift();

        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("leftover_reads",   128'(exp_rd_q.size()),  128'(0));
        check("leftover_columns", 128'(exp_col_q.size()), 128'(0));
        check("leftover_acks",    128'(exp_ack_q.size()), 128'(0));
        check("leftover_errors",  128'(exp_err_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
